fifo_sync_flex: RTL and testbench

Single-clock FIFO with arbitrary (non-power-of-two) depth, a registered fill-level output, synchronous flush and optionally sticky error flags. It is the general-purpose successor for capture and streaming buffers in the FPGA designs. All depths use flop storage, so simulation and synthesis behave identically.

---
 rtl/fifo_sync_flex_pkg.sv | 37 +++
 rtl/fifo_sync_flex_ptr_mod.sv | 49 ++++
 rtl/fifo_sync_flex.sv | 183 ++++++++++++++++++
 tb/tb_fifo_sync_flex.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_flex_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_flex_pkg
// Shared definitions for the synchronous FIFO family: a constant clog2
// function used to size pointers and counters, the error-flag behaviour
// encodings, and a packed struct grouping the two error flags.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_sync_flex_pkg;

   // Overflow/underflow behaviour: one-cycle pulse or hold-until-flush.
   typedef enum logic {
      ERR_PULSE  = 1'b0,
      ERR_STICKY = 1'b1
   } err_mode_e;

   // Overflow and underflow travel together through the flag logic.
   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_flags_t;

   // Ceiling log2, usable in parameter defaults. clog2(1) = 0.
   function automatic int clog2(input int unsigned value);
      int res;
      res = 0;
      while ((64'd1 << res) < 64'(value)) begin
         res = res + 1;
      end
      return res;
   endfunction

   // Maps the integer sticky parameter onto the error-mode encoding.
   function automatic err_mode_e err_mode_from_param(input int sticky);
      return (sticky != 0) ? ERR_STICKY : ERR_PULSE;
   endfunction

endpackage : fifo_sync_flex_pkg

// File: rtl/fifo_sync_flex_ptr_mod.sv
// -----------------------------------------------------------------------------
// fifo_ptr_mod
// Modulo-pDEPTH pointer register. Increments on inc_i, wraps from pDEPTH-1
// to 0, and clears synchronously on clr_i (clear wins over increment).
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   clr_i  in   synchronous clear to 0
//   inc_i  in   increment enable
//   ptr_o  out  current pointer value, 0..pDEPTH-1
// -----------------------------------------------------------------------------
module fifo_ptr_mod
   import fifo_sync_flex_pkg::*;
#(
   parameter int pDEPTH = 32,
   parameter int pPTR_W = clog2(pDEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [pPTR_W-1:0] ptr_o
);

   logic [pPTR_W-1:0] ptr_q;
   logic [pPTR_W-1:0] ptr_d;

   // The explicit wrap compare is what makes non-power-of-two depths work;
   // a plain binary rollover would only be correct for 2**pPTR_W entries.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = (ptr_q == pPTR_W'(pDEPTH - 1)) ? '0 : ptr_q + pPTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule : fifo_ptr_mod

// File: rtl/fifo_sync_flex.sv
// -----------------------------------------------------------------------------
// fifo_sync_flex
// Single-clock FIFO of any depth 2..65536 built from flops, with a registered
// fill level, synchronous flush, programmable thresholds, optional
// first-word-fall-through read data and optionally sticky error flags.
// Ports:
//   clk                    in   clock
//   rst_n                  in   asynchronous active-low reset
//   flush                  in   synchronous clear of pointers, count, flags
//   wen / wdata            in   write request and data
//   full                   out  count == pDEPTH
//   almost_full            out  count >= pDEPTH-1
//   full_threshold_value   in   programmable full level
//   full_threshold         out  count >= full_threshold_value
//   overflow               out  registered: write attempted while full
//   ren                    in   read request
//   rdata                  out  read data (registered or fall-through)
//   empty                  out  count == 0
//   almost_empty           out  count <= 1
//   empty_threshold_value  in   programmable empty level
//   empty_threshold        out  count <= empty_threshold_value
//   underflow              out  registered: read attempted while empty
//   count                  out  registered fill level, 0..pDEPTH
// -----------------------------------------------------------------------------
module fifo_sync_flex
   import fifo_sync_flex_pkg::*;
#(
   parameter int pDATA_WIDTH    = 8,
   parameter int pDEPTH         = 32,
   parameter int pFALLTHROUGH   = 0,
   parameter int pSTICKY_ERRORS = 0,
   parameter int pCNT_W         = clog2(pDEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   wen,
   input  logic [pDATA_WIDTH-1:0] wdata,
   output logic                   full,
   output logic                   almost_full,
   input  logic [pCNT_W-1:0]      full_threshold_value,
   output logic                   full_threshold,
   output logic                   overflow,
   input  logic                   ren,
   output logic [pDATA_WIDTH-1:0] rdata,
   output logic                   empty,
   output logic                   almost_empty,
   input  logic [pCNT_W-1:0]      empty_threshold_value,
   output logic                   empty_threshold,
   output logic                   underflow,
   output logic [pCNT_W-1:0]      count
);

   localparam int        PTR_W    = clog2(pDEPTH);
   localparam err_mode_e ERR_MODE = err_mode_from_param(pSTICKY_ERRORS);

   logic                   wr_ok;
   logic                   rd_ok;
   logic [PTR_W-1:0]       waddr;
   logic [PTR_W-1:0]       raddr;
   logic [pCNT_W-1:0]      count_q;
   logic [pCNT_W-1:0]      count_d;
   err_flags_t             err_event;
   err_flags_t             err_q;
   err_flags_t             err_d;
   logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];

   // ---------------------------------------------------------------------------
   // Flags: pure compares of the registered count, so they move one cycle
   // after the operation that changed the level.
   // ---------------------------------------------------------------------------
   assign full            = (count_q == pCNT_W'(pDEPTH));
   assign almost_full     = (count_q >= pCNT_W'(pDEPTH - 1));
   assign empty           = (count_q == '0);
   assign almost_empty    = (count_q <= pCNT_W'(1));
   assign full_threshold  = (count_q >= full_threshold_value);
   assign empty_threshold = (count_q <= empty_threshold_value);
   assign count           = count_q;

   // Acceptance uses only this cycle's flags: a read does not make room for
   // a same-cycle write when full, nor does a write feed a same-cycle read.
   assign wr_ok = wen & ~full  & ~flush;
   assign rd_ok = ren & ~empty & ~flush;

   // ---------------------------------------------------------------------------
   // Pointers
   // ---------------------------------------------------------------------------
   fifo_ptr_mod #(
      .pDEPTH (pDEPTH),
      .pPTR_W (PTR_W)
   ) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (flush),
      .inc_i (wr_ok),
      .ptr_o (waddr)
   );

   fifo_ptr_mod #(
      .pDEPTH (pDEPTH),
      .pPTR_W (PTR_W)
   ) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (flush),
      .inc_i (rd_ok),
      .ptr_o (raddr)
   );

   // ---------------------------------------------------------------------------
   // Fill level and error flags
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned; that is what keeps synthesis from inferring a latch.
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (wr_ok && !rd_ok) begin
         count_d = count_q + pCNT_W'(1);
      end else if (rd_ok && !wr_ok) begin
         count_d = count_q - pCNT_W'(1);
      end
   end

   // Events already exclude flush, so pulse mode clears on flush by itself.
   assign err_event.overflow  = wen & full  & ~flush;
   assign err_event.underflow = ren & empty & ~flush;

   always_comb begin
      err_d = err_event;
      if (ERR_MODE == ERR_STICKY) begin
         err_d = flush ? '0 : err_flags_t'(err_q | err_event);
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         err_q   <= '0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign overflow  = err_q.overflow;
   assign underflow = err_q.underflow;

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   // NOTE: the array has no reset; its contents are only observable after a
   // write, and leaving reset off keeps it mappable to plain enable flops.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[waddr] <= wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Read data
   // ---------------------------------------------------------------------------
   if (pFALLTHROUGH != 0) begin : g_fwft
      // Head entry is always presented; meaningless while empty.
      assign rdata = mem_q[raddr];
   end else begin : g_reg
      logic [pDATA_WIDTH-1:0] rdata_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q <= '0;
         end else if (rd_ok) begin
            rdata_q <= mem_q[raddr];
         end
      end

      assign rdata = rdata_q;
   end

endmodule : fifo_sync_flex

// File: tb/tb_fifo_sync_flex.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_flex
// Drives two fifo_sync_flex instances (depth 24) with identical stimulus:
//   u_dut0: registered read data, pulsed error flags
//   u_dut1: first-word-fall-through, sticky error flags
// A queue-based reference model predicts contents, level and flags after each
// clock edge and pushes the prediction into a scoreboard queue; a monitor on
// the falling edge pops each prediction and compares it with both DUTs.
// -----------------------------------------------------------------------------
module tb_fifo_sync_flex;

   localparam int DW    = 8;
   localparam int DEPTH = 24;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          wen   = 1'b0;
   logic          ren   = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [CW-1:0] fthr  = CW'(10);
   logic [CW-1:0] ethr  = CW'(3);

   logic          full0, afull0, fth0, ovf0, empty0, aempty0, eth0, unf0;
   logic [DW-1:0] rdata0;
   logic [CW-1:0] count0;
   logic          full1, afull1, fth1, ovf1, empty1, aempty1, eth1, unf1;
   logic [DW-1:0] rdata1;
   logic [CW-1:0] count1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_sync_flex #(
      .pDATA_WIDTH    (DW),
      .pDEPTH         (DEPTH),
      .pFALLTHROUGH   (0),
      .pSTICKY_ERRORS (0)
   ) u_dut0 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .flush                 (flush),
      .wen                   (wen),
      .wdata                 (wdata),
      .full                  (full0),
      .almost_full           (afull0),
      .full_threshold_value  (fthr),
      .full_threshold        (fth0),
      .overflow              (ovf0),
      .ren                   (ren),
      .rdata                 (rdata0),
      .empty                 (empty0),
      .almost_empty          (aempty0),
      .empty_threshold_value (ethr),
      .empty_threshold       (eth0),
      .underflow             (unf0),
      .count                 (count0)
   );

   fifo_sync_flex #(
      .pDATA_WIDTH    (DW),
      .pDEPTH         (DEPTH),
      .pFALLTHROUGH   (1),
      .pSTICKY_ERRORS (1)
   ) u_dut1 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .flush                 (flush),
      .wen                   (wen),
      .wdata                 (wdata),
      .full                  (full1),
      .almost_full           (afull1),
      .full_threshold_value  (fthr),
      .full_threshold        (fth1),
      .overflow              (ovf1),
      .ren                   (ren),
      .rdata                 (rdata1),
      .empty                 (empty1),
      .almost_empty          (aempty1),
      .empty_threshold_value (ethr),
      .empty_threshold       (eth1),
      .underflow             (unf1),
      .count                 (count1)
   );

   // ---------------------------------------------------------------------------
   // Reference model and scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      int            cnt;
      bit            ovf_p;
      bit            unf_p;
      bit            ovf_s;
      bit            unf_s;
      logic [DW-1:0] rd_reg;
      bit            head_valid;
      logic [DW-1:0] head;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model_q[$];
   bit            m_ovf_p, m_unf_p, m_ovf_s, m_unf_s;
   logic [DW-1:0] m_rd_reg;

   task automatic model_reset();
      model_q.delete();
      exp_q.delete();
      m_ovf_p  = 1'b0;
      m_unf_p  = 1'b0;
      m_ovf_s  = 1'b0;
      m_unf_s  = 1'b0;
      m_rd_reg = '0;
   endtask

   task automatic model_step();
      exp_t e;
      bit   m_full  = (model_q.size() == DEPTH);
      bit   m_empty = (model_q.size() == 0);
      if (flush) begin
         model_q.delete();
         m_ovf_p = 1'b0;
         m_unf_p = 1'b0;
         m_ovf_s = 1'b0;
         m_unf_s = 1'b0;
      end else begin
         m_ovf_p = wen && m_full;
         m_unf_p = ren && m_empty;
         m_ovf_s = m_ovf_s | m_ovf_p;
         m_unf_s = m_unf_s | m_unf_p;
         if (ren && !m_empty) m_rd_reg = model_q.pop_front();
         if (wen && !m_full)  model_q.push_back(wdata);
      end
      e.cnt        = model_q.size();
      e.ovf_p      = m_ovf_p;
      e.unf_p      = m_unf_p;
      e.ovf_s      = m_ovf_s;
      e.unf_s      = m_unf_s;
      e.rd_reg     = m_rd_reg;
      e.head_valid = (model_q.size() != 0);
      e.head       = e.head_valid ? model_q[0] : '0;
      exp_q.push_back(e);
   endtask

   initial begin : model_proc
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_flags(input string tag, input int cnt,
                              input logic [CW-1:0] c, input logic f, input logic af,
                              input logic em, input logic ae, input logic ft,
                              input logic et, input logic ov, input logic un,
                              input bit eov, input bit eun);
      check({tag, ".count"},           32'(c),  32'(cnt));
      check({tag, ".full"},            32'(f),  32'(cnt == DEPTH));
      check({tag, ".almost_full"},     32'(af), 32'(cnt >= DEPTH - 1));
      check({tag, ".empty"},           32'(em), 32'(cnt == 0));
      check({tag, ".almost_empty"},    32'(ae), 32'(cnt <= 1));
      check({tag, ".full_threshold"},  32'(ft), 32'(cnt >= int'(fthr)));
      check({tag, ".empty_threshold"}, 32'(et), 32'(cnt <= int'(ethr)));
      check({tag, ".overflow"},        32'(ov), 32'(eov));
      check({tag, ".underflow"},       32'(un), 32'(eun));
   endtask

   task automatic check_reset_state();
      check_flags("rst0", 0, count0, full0, afull0, empty0, aempty0, fth0, eth0, ovf0, unf0, 1'b0, 1'b0);
      check_flags("rst1", 0, count1, full1, afull1, empty1, aempty1, fth1, eth1, ovf1, unf1, 1'b0, 1'b0);
      check("rst0.rdata", 32'(rdata0), 32'h0);
   endtask

   initial begin : monitor_proc
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_flags("dut0", e.cnt, count0, full0, afull0, empty0, aempty0, fth0, eth0,
                        ovf0, unf0, e.ovf_p, e.unf_p);
            check_flags("dut1", e.cnt, count1, full1, afull1, empty1, aempty1, fth1, eth1,
                        ovf1, unf1, e.ovf_s, e.unf_s);
            check("dut0.rdata", 32'(rdata0), 32'(e.rd_reg));
            if (e.head_valid) check("dut1.rdata", 32'(rdata1), 32'(e.head));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus: one call = inputs held for one clock cycle.
   // ---------------------------------------------------------------------------
   task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
      @(posedge clk);
      #1;
      wen   = w;
      wdata = d;
      ren   = r;
      flush = f;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin : stim_proc
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      rst_n = 1'b1;

      // Fill 0..23 (thresholds 10/3 crossed on the way), refused 25th write,
      // drain in order, then a read on empty.
      for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
      idle(2);

      // Hold level 5 through 100 simultaneous write/read pairs (wraps 23->0).
      for (int i = 0; i < 5; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) drive(1'b1, DW'($urandom), 1'b1, 1'b0);

      // Full with wen&ren: read accepted, write refused, overflow.
      for (int i = 0; i < DEPTH - 5; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
      drive(1'b1, 8'h99, 1'b1, 1'b0);
      idle(2);

      // Empty with wen&ren: write accepted, read refused, underflow.
      for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, '0, 1'b1, 1'b0);
      drive(1'b1, 8'h3C, 1'b1, 1'b0);
      idle(1);

      // Normal traffic keeps sticky flags up; flush with wen clears them.
      for (int i = 0; i < 6; i++) drive(1'b1, DW'($urandom), i[0], 1'b0);
      drive(1'b1, 8'h77, 1'b0, 1'b1);
      idle(2);

      // Fall-through: data visible the cycle after the write, no ren.
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, '0, 1'b1, 1'b0);
      idle(1);

      // Randomized traffic with occasional flush and threshold changes.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            fthr = CW'($urandom_range(0, DEPTH));
            ethr = CW'($urandom_range(0, DEPTH));
         end
         drive($urandom_range(0, 99) < 55, DW'($urandom),
               $urandom_range(0, 99) < 45, $urandom_range(0, 79) == 0);
      end

      // Reset in the middle of filling clears state immediately.
      fthr = CW'(10);
      ethr = CW'(3);
      drive(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) drive(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      wen   = 1'b0;
      #1;
      check_reset_state();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 8'h5A, 1'b0, 1'b0);
      idle(3);
      drive(1'b0, '0, 1'b1, 1'b0);
      idle(3);
      @(negedge clk);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fifo_sync_flex
